// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared state encoding and default sizing for the frequency meter
package freq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } freq_state_e;

  localparam int DEF_GATE_CYCLES = 100000000;
  localparam int DEF_CNT_W       = 27;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer plus rising-edge detector
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic meta, sync, sync_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  // Strobe is valid in the cycle ending on the third edge after the rise
  assign rise_pulse = sync & ~sync_d;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - counts sig_in rising edges per fixed gate window
module freq_meter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             overflow,
  output logic             gate
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

  freq_state_e      state, next_state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_next;
  logic             win_ovf, ovf_next;
  logic             rise, last, cnt_max;

  sync_edge_detect u_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (sig_in),
    .rise_pulse (rise)
  );

  assign last      = (gate_cnt == LAST);
  assign cnt_max   = &edge_cnt;
  assign edge_next = (rise && !cnt_max) ? edge_cnt + 1'b1 : edge_cnt;
  assign ovf_next  = win_ovf | (rise & cnt_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    gate       = 1'b0;
    case (state)
      IDLE: if (enable) next_state = MEASURE;
      MEASURE: begin
        gate = 1'b1;
        // The final window cycle always completes, even if enable just fell
        if (!enable) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      win_ovf    <= 1'b0;
      freq_out   <= '0;
      overflow   <= 1'b0;
      freq_valid <= 1'b0;
    end else if (state != MEASURE || (!enable && !last)) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      win_ovf    <= 1'b0;
      freq_valid <= 1'b0;
    end else if (last) begin
      freq_out   <= edge_next;
      overflow   <= ovf_next;
      freq_valid <= 1'b1;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      win_ovf    <= 1'b0;
    end else begin
      gate_cnt   <= gate_cnt + 1'b1;
      edge_cnt   <= edge_next;
      win_ovf    <= ovf_next;
      freq_valid <= 1'b0;
    end
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 100000000, meaning the number of clock cycles per measurement window (1 s at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 27, meaning the width of the edge count and result.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run measurements while high.
REQ-006 SHALL have port sig_in  input  1  measured signal, asynchronous to clock (e.g. a divided clock).
REQ-007 SHALL have port freq_out  output  CNT_W  rising edges counted in the last completed window.
REQ-008 SHALL have port freq_valid  output  1  one-cycle pulse when freq_out updates.
REQ-009 SHALL have port overflow  output  1  last completed window saturated.
REQ-010 SHALL have port gate  output  1  high while a window is in progress.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then detect rising edges by comparing the synchronized value with a third delayed flop.
REQ-012 SHALL assert the internal edge strobe exactly 3 clock edges after a sig_in rise that meets setup (fixed latency, one strobe per rise).
REQ-013 SHALL implement FSM states IDLE and MEASURE.
REQ-014 IDLE: gate=0, gate and edge counters held at 0; enable=1 -> MEASURE on the next edge.
REQ-015 MEASURE: gate=1, gate counter increments every cycle from 0 to GATE_CYCLES-1.
REQ-016 MEASURE: edge counter increments on each edge strobe and saturates at 2^CNT_W-1; a strobe at saturation sets the internal window-overflow flag.
REQ-017 In the cycle the gate counter equals GATE_CYCLES-1, the final-cycle strobe SHALL be included; on that edge freq_out <= saturated total, overflow <= window-overflow flag, freq_valid <= 1.
REQ-018 On that same edge, counters and window flag SHALL clear, and the FSM SHALL stay in MEASURE if enable=1 (back-to-back windows, no dead cycle), else go to IDLE.
REQ-019 enable=0 during MEASURE (before the final cycle) SHALL abort: return to IDLE next edge, discard the count, no freq_valid, freq_out and overflow unchanged.
REQ-020 freq_valid SHALL be high for exactly one cycle per completed window and low otherwise.
REQ-021 freq_out and overflow SHALL hold their value between windows.
REQ-022 Synchronizer flops SHALL run in all states, so an edge arriving in the first MEASURE cycle is counted only if its strobe falls inside the window.

Reset
REQ-023 reset=1 SHALL immediately force: FSM=IDLE, freq_out=0, freq_valid=0, overflow=0, gate=0, all counters and synchronizer flops = 0.
REQ-024 Reset mid-window SHALL discard the window; after release, measurement restarts from IDLE.

Structure
REQ-025 Package freq_pkg SHALL hold the FSM state encoding (IDLE, MEASURE) and the default GATE_CYCLES/CNT_W constants.
REQ-026 Synchronizer plus edge detector SHALL be a sub-module sync_edge_detect (inputs clock, reset, async_in; output rise_pulse).
REQ-027 The gate counter width SHALL be $clog2(GATE_CYCLES).

Verification (GATE_CYCLES=100, CNT_W=27 unless stated)
REQ-028 sig_in period 10 clocks, enable=1 -> freq_valid every 100 cycles, freq_out=10, overflow=0.
REQ-029 sig_in toggled every clock (period 2) -> freq_out=50; sig_in held high -> freq_out=0.
REQ-030 CNT_W=4, sig_in period 2 -> freq_out=15, overflow=1; next window at period 10 -> freq_out=10, overflow=0.
REQ-031 enable dropped at cycle 50 of a window -> no freq_valid, gate=0 next cycle, freq_out keeps previous value.
REQ-032 reset asserted at cycle 40 of a window -> all outputs 0 immediately; after release with sig_in period 10, first freq_valid shows freq_out=10.
